// File: rtl/cfu_quantizer_pipe_if.sv
// cfu_quantizer_pipe_if: accumulator input and result output valid/ready streams.
interface cfu_quantizer_pipe_if #(
    parameter int ACC_W = 32,
    parameter int CH_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CH_W-1:0]  out_ch;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_ch);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_ch);
endinterface

// File: rtl/cfu_quantizer_pipe.sv
// cfu_quantizer_pipe: 4-stage per-channel int32 requantizer (TFLite MultiplyByQuantizedMultiplier).
// Optional saturation counter output sat_count enabled by QUANT_SAT_CNT_EN.
module cfu_quantizer_pipe #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int ACC_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [31:0]         cfg_bias,
    input  logic [31:0]         cfg_mul,
    input  logic [5:0]          cfg_shift,
    input  logic                ch_clear,
    input  logic [31:0]         offset,
    input  logic [31:0]         act_min,
    input  logic [31:0]         act_max,
    cfu_quantizer_pipe_if.slave bus,
    output logic                busy
`ifdef QUANT_SAT_CNT_EN
    ,
    output logic [15:0]         sat_count
`endif
);
    logic [31:0]     bias_t  [NUM_CH];
    logic [31:0]     mul_t   [NUM_CH];
    logic [5:0]      shift_t [NUM_CH];
    logic [CH_W-1:0] ch_cnt, ch_use;
    logic            adv, accept;
    logic            v1, v2, v3;
    logic [CH_W-1:0] ch1, ch2, ch3;
    logic [31:0]     sh1, mul1, pre3;
    logic [5:0]      rs1, rs2, rs3;
    logic [63:0]     ab2;
    logic            ovf2;
    logic [31:0]     acc_s, shifted_s, pre_s, scaled_s, v_s, res_s;
    logic [5:0]      sh_s, ls_s, rs_s;
    logic [63:0]     sum3, pre64, mask4, rem4, thr4;
    logic            lo_s, hi_s;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign accept       = bus.in_valid && adv;
    assign ch_use       = ch_clear ? '0 : ch_cnt;
    assign busy         = v1 || v2 || v3 || bus.out_valid;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NUM_CH; i++) begin
                bias_t[i]  <= '0;
                mul_t[i]   <= '0;
                shift_t[i] <= '0;
            end
        else if (cfg_we) begin
            bias_t[cfg_ch]  <= cfg_bias;
            mul_t[cfg_ch]   <= cfg_mul;
            shift_t[cfg_ch] <= cfg_shift;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            ch_cnt <= '0;
        else if (ch_clear || accept)
            ch_cnt <= accept ? ch_use + 1'b1 : '0;

    // S1: bias add and left shift; table entry is read before any same-cycle write lands
    assign sh_s      = shift_t[ch_use];
    assign ls_s      = sh_s[5] ? '0 : sh_s;
    assign rs_s      = sh_s[5] ? -sh_s : '0;
    assign acc_s     = 32'($signed(bus.in_data)) + bias_t[ch_use];
    assign shifted_s = acc_s << ls_s;

    // S3: round-half-away doubling high multiply, then truncate toward zero
    assign sum3  = ab2 + (ab2[63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000);
    assign pre_s = ovf2 ? 32'h7FFF_FFFF : 32'($signed(sum3 + (sum3[63] ? 64'h7FFF_FFFF : 64'h0)) >>> 31);

    // S4: rounding right shift, zero point, clamp (low bound wins)
    assign pre64    = 64'($signed(pre3));
    assign mask4    = (64'd1 << rs3) - 64'd1;
    assign rem4     = pre64 & mask4;
    assign thr4     = (mask4 >> 1) + 64'(pre3[31]);
    assign scaled_s = 32'($signed(pre64) >>> rs3) + 32'(rem4 > thr4);
    assign v_s      = scaled_s + offset;
    assign lo_s     = $signed(v_s) < $signed(act_min);
    assign hi_s     = $signed(v_s) > $signed(act_max);
    assign res_s    = lo_s ? act_min : hi_s ? act_max : v_s;

    always_ff @(posedge clk)
        if (adv) begin
            if (accept) begin
                ch1  <= ch_use;
                sh1  <= shifted_s;
                mul1 <= mul_t[ch_use];
                rs1  <= rs_s;
            end
            if (v1) begin
                ch2  <= ch1;
                ab2  <= 64'($signed(sh1)) * 64'($signed(mul1));
                ovf2 <= sh1 == 32'h8000_0000 && mul1 == 32'h8000_0000;
                rs2  <= rs1;
            end
            if (v2) begin
                ch3  <= ch2;
                pre3 <= pre_s;
                rs3  <= rs2;
            end
        end

`ifdef QUANT_SAT_CNT_EN
    logic sat_flag, sat_hand;
    assign sat_hand = bus.out_valid && bus.out_ready && sat_flag;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            sat_count <= '0;
        else if (ch_clear)
            sat_count <= {15'd0, sat_hand};
        else if (sat_hand && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
`ifdef QUANT_SAT_CNT_EN
            sat_flag      <= 1'b0;
`endif
        end else if (adv) begin
            v1            <= accept;
            v2            <= v1;
            v3            <= v2;
            bus.out_valid <= v3;
            if (v3) begin
                bus.out_data <= res_s;
                bus.out_ch   <= ch3;
`ifdef QUANT_SAT_CNT_EN
                sat_flag     <= lo_s || hi_s;
`endif
            end
        end
endmodule

// File: tb/tb_cfu_quantizer_pipe.sv
// tb_cfu_quantizer_pipe: directed sequence with a scoreboard of model-predicted results.
module tb_cfu_quantizer_pipe;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int ACC_W  = 32;
    localparam int IMIN   = 32'h8000_0000;

    typedef struct {
        logic [31:0]     d;
        logic [CH_W-1:0] c;
        bit              sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [31:0]     cfg_bias = '0, cfg_mul = '0;
    logic [5:0]      cfg_shift = '0;
    logic            ch_clear = 1'b0;
    logic [31:0]     offset = '0, act_min = '0, act_max = '0;
    logic            busy;
`ifdef QUANT_SAT_CNT_EN
    logic [15:0]     sat_count;
    int              exp_sat = 0;
`endif

    cfu_quantizer_pipe_if #(.ACC_W(ACC_W), .CH_W(CH_W)) bus ();

    cfu_quantizer_pipe #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_bias(cfg_bias),
        .cfg_mul(cfg_mul), .cfg_shift(cfg_shift), .ch_clear(ch_clear), .offset(offset),
        .act_min(act_min), .act_max(act_max), .bus(bus), .busy(busy)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    exp_t q[$];
    int   sb[NUM_CH], sm[NUM_CH], ss[NUM_CH];
    int   cnt = 0;
    bit   pat_en = 0;
    int   pidx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference arithmetic written directly from the TFLite definition using 64-bit integers.
    function automatic logic [31:0] model(input int x, input int b, input int m, input int s, output bit cl);
        int a, ls, rs, pre, sc, v, mn, mx;
        longint ab, nud, lp, mask, rem, thr;
        a  = x + b;
        ls = s > 0 ? s : 0;
        rs = s < 0 ? -s : 0;
        a  = a << ls;
        if (a == IMIN && m == IMIN) pre = 32'h7FFF_FFFF;
        else begin
            ab  = longint'(a) * longint'(m);
            nud = ab >= 0 ? 64'sd1073741824 : 64'sd1 - 64'sd1073741824;
            pre = int'((ab + nud) / 64'sd2147483648);
        end
        if (rs == 0) sc = pre;
        else begin
            lp   = pre;
            mask = (64'sd1 << rs) - 1;
            rem  = lp & mask;
            thr  = (mask >>> 1) + (pre < 0 ? 1 : 0);
            sc   = int'((lp >>> rs) + (rem > thr ? 1 : 0));
        end
        v  = sc + int'(offset);
        mn = act_min;
        mx = act_max;
        cl = v < mn || v > mx;
        return v < mn ? mn : v > mx ? mx : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pat_en) begin
            bus.out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            pidx++;
        end
    endtask

    task automatic cfg(input int c, input int b, input int m, input int s);
        cfg_we = 1; cfg_ch = c[CH_W-1:0]; cfg_bias = b; cfg_mul = m; cfg_shift = s[5:0];
        step();
        cfg_we = 0;
        sb[c] = b; sm[c] = m; ss[c] = s;
    endtask

    task automatic send(input logic [31:0] x, input bit clr, input bit directed, input logic [31:0] want);
        exp_t e;
        int   ch, n;
        bit   acc, cl;
        bus.in_valid = 1; bus.in_data = x; ch_clear = clr;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        chk("accept", {31'd0, acc}, 32'd1);
        ch    = clr ? 0 : cnt;
        e.d   = model(x, sb[ch], sm[ch], ss[ch], cl);
        e.sat = cl;
        e.c   = ch[CH_W-1:0];
        if (directed) e.d = want;
        q.push_back(e);
        cnt = (ch + 1) % NUM_CH;
        ch_clear = 0;
        if (cfg_we) begin
            sb[cfg_ch] = cfg_bias; sm[cfg_ch] = cfg_mul; ss[cfg_ch] = {{26{cfg_shift[5]}}, cfg_shift};
            cfg_we = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 0;
        while (q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
        step();
        step();
    endtask

    logic [31:0]     hd;
    logic [CH_W-1:0] hc;
    bit              stall = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   hand, hs;
        if (rst) begin
            stall = 0;
`ifdef QUANT_SAT_CNT_EN
            exp_sat = 0;
`endif
        end else begin
`ifdef QUANT_SAT_CNT_EN
            chk("sat_count", {16'd0, sat_count}, exp_sat);
`endif
            if (stall) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_data", bus.out_data, hd);
                chk("stall_ch", {29'd0, bus.out_ch}, {29'd0, hc});
            end
            hand = bus.out_valid && bus.out_ready;
            hs   = 0;
            if (hand) begin
                chk("sb_nonempty", {31'd0, q.size() > 0}, 32'd1);
                if (q.size() > 0) begin
                    e  = q.pop_front();
                    hs = e.sat;
                    chk("out_data", bus.out_data, e.d);
                    chk("out_ch", {29'd0, bus.out_ch}, {29'd0, e.c});
                end
            end
`ifdef QUANT_SAT_CNT_EN
            if (ch_clear) exp_sat = (hand && hs) ? 1 : 0;
            else if (hand && hs && exp_sat < 65535) exp_sat++;
`endif
            stall = bus.out_valid && !bus.out_ready;
            hd    = bus.out_data;
            hc    = bus.out_ch;
        end
    end

    initial begin
        int n;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        for (int i = 0; i < NUM_CH; i++) begin sb[i] = 0; sm[i] = 0; ss[i] = 0; end
        step(); step();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_ch", {29'd0, bus.out_ch}, 32'd0);
`ifdef QUANT_SAT_CNT_EN
        chk("rst_sat", {16'd0, sat_count}, 32'd0);
`endif
        rst = 0;
        offset = 0; act_min = -128; act_max = 127; bus.out_ready = 1;
        cfg(0, 0, 32'h4000_0000, 0);
        cfg(1, 1, 32'h4000_0000, -1);
        cfg(2, 0, 32'h8000_0000, 0);
        cfg(3, -7, 32'h5A5A_5A5A, 2);
        cfg(4, 100, 32'h7FFF_FFFF, -5);
        cfg(5, 0, 32'hC000_0000, 0);
        cfg(6, 3, 32'h4000_0000, -32);
        cfg(7, 0, 32'h4000_0000, 31);

        send(100, 0, 1, 50);
        bus.in_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 10);
        chk("latency", n, 4);
        drain();

        send(-101, 1, 1, -50);
        drain();

        send(7, 1, 0, 0);
        send(100, 0, 1, 26);
        drain();

        send(32'h8000_0000, 0, 1, 127);
        drain();
`ifdef QUANT_SAT_CNT_EN
        chk("sat_after_ovf", {16'd0, sat_count}, 32'd1);
`endif

        // same-cycle write to the accepting channel: this beat must see the old entry
        cfg_we = 1; cfg_ch = 3; cfg_bias = 500; cfg_mul = 32'h4000_0000; cfg_shift = 0;
        send(1000, 0, 0, 0);
        drain();

        offset = 3; act_min = -1000; act_max = 1000;
        pat_en = 1; pidx = 0;
        for (int i = 0; i < 11; i++)
            send(i % 2 ? $urandom() : $urandom_range(4000, 0) - 2000, i == 7, 0, 0);
        drain();
        pat_en = 0; bus.out_ready = 1;

        bus.out_ready = 0;
        send(11, 0, 0, 0);
        send(22, 0, 0, 0);
        send(33, 0, 0, 0);
        bus.in_valid = 0;
        step();
        chk("inflight_busy", {31'd0, busy}, 32'd1);
        chk("inflight_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        q.delete();
        for (int i = 0; i < NUM_CH; i++) begin sb[i] = 0; sm[i] = 0; ss[i] = 0; end
        cnt = 0;
        step(); step();
        rst = 0;
        offset = 5; act_min = -128; act_max = 127; bus.out_ready = 1;
        send(1000, 0, 1, 5);
        drain();
        offset = 300;
        send(-4, 0, 1, 127);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
